// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared constants for the DES key schedule: PC-1 and PC-2 selection tables
// (entries are DES bit numbers, bit 1 = most significant), the per-round
// left-rotate schedule, the scheduler state type and 28-bit rotate helpers.
// No ports.
// -----------------------------------------------------------------------------
package des_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // PC-1: 64-bit key -> 56 bits. First 28 entries form C, last 28 form D.
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // PC-2: 56-bit {C,D} -> 48-bit subkey.
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Left-rotate amount applied before producing round r (index r-1).
    localparam logic [1:0] SHIFT_TAB [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

endpackage

// File: rtl/des_pc2.sv
// -----------------------------------------------------------------------------
// des_pc2
// Purely combinational DES Permuted Choice 2.
//   cd_i [55:0]  {C,D} halves, DES bit 1 at index 55
//   sk_o [47:0]  48-bit subkey, DES bit 1 at index 47
// -----------------------------------------------------------------------------
module des_pc2 (
    input  logic [55:0] cd_i,
    output logic [47:0] sk_o
);
    import des_pkg::*;

    // DES bit n of {C,D} lives at index 56-n.
    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        sk_o = '0;
        for (int i = 0; i < 48; i++) begin
            sk_o[6'(47 - i)] = cd_i[6'(56 - PC2_TAB[i])];
        end
    end

    // PC-2 drops DES bits 9,18,22,25,35,38,43,54 of {C,D}.
    logic unused_cd;
    assign unused_cd = ^{cd_i[47], cd_i[38], cd_i[34], cd_i[31],
                         cd_i[21], cd_i[18], cd_i[13], cd_i[2]};

endmodule

// File: rtl/des_key_scheduler.sv
// -----------------------------------------------------------------------------
// des_key_scheduler
// Streams the 16 DES round subkeys for one key, in encrypt (K1..K16) or
// decrypt (K16..K1) order, with a valid/ready handshake on the output.
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   key_in    64-bit raw key, DES bit 1 = MSB (index 63); parity bits unused
//   mode      0 = encrypt order, 1 = decrypt order (ignored when DEC_EN = 0)
//   start     request, accepted only while ready
//   ready     high in IDLE
//   sk_out    current subkey, DES bit 1 = MSB (index 47)
//   sk_round  DES round of sk_out, rounds 1..16 encoded 0..15
//   sk_valid  high in RUN
//   sk_ready  consumer accept; a transfer is sk_valid & sk_ready
//   done      pulse in the cycle of the 16th transfer
// Parameters: DEC_EN enables decrypt order; HOLD_KEY keeps the last halves
// after done (0 clears them).
// -----------------------------------------------------------------------------
module des_key_scheduler #(
    parameter int DEC_EN   = 1,
    parameter int HOLD_KEY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] key_in,
    input  logic        mode,
    input  logic        start,
    output logic        ready,
    output logic [47:0] sk_out,
    output logic [3:0]  sk_round,
    output logic        sk_valid,
    input  logic        sk_ready,
    output logic        done
);
    import des_pkg::*;

    state_t      state_q;
    logic [27:0] c_q, d_q;
    logic [27:0] c_d, d_d;
    logic [3:0]  cnt_q;
    logic        mode_q;
    logic [55:0] pc1_key;
    logic        mode_eff;
    logic        last_step;

    // PC-1 straight from the key port; DES bit n sits at index 64-n.
    always_comb begin
        pc1_key = '0;
        for (int i = 0; i < 56; i++) begin
            pc1_key[6'(55 - i)] = key_in[6'(64 - PC1_TAB[i])];
        end
    end

    logic unused_parity;
    assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                             key_in[24], key_in[16], key_in[8],  key_in[0]};

    assign mode_eff  = (DEC_EN != 0) && mode;
    assign last_step = (cnt_q == 4'd15);

    // Halves for the next subkey. Encrypt pre-rotates left by the next
    // round's shift; decrypt undoes the shift of the round just produced.
    always_comb begin
        c_d = c_q;
        d_d = d_q;
        if (mode_q) begin
            c_d = rotr28(c_q, SHIFT_TAB[4'd15 - cnt_q]);
            d_d = rotr28(d_q, SHIFT_TAB[4'd15 - cnt_q]);
        end else begin
            c_d = rotl28(c_q, SHIFT_TAB[cnt_q + 4'd1]);
            d_d = rotl28(d_q, SHIFT_TAB[cnt_q + 4'd1]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is
    // sampled on the clock edge, so it lives inside the clocked branch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        mode_q  <= mode_eff;
                        cnt_q   <= '0;
                        // Decrypt starts from the unrotated halves (K16);
                        // encrypt applies round 1's shift up front (K1).
                        if (mode_eff) begin
                            c_q <= pc1_key[55:28];
                            d_q <= pc1_key[27:0];
                        end else begin
                            c_q <= rotl28(pc1_key[55:28], SHIFT_TAB[0]);
                            d_q <= rotl28(pc1_key[27:0],  SHIFT_TAB[0]);
                        end
                    end
                end
                S_RUN: begin
                    if (sk_ready) begin
                        if (last_step) begin
                            state_q <= S_IDLE;
                            if (HOLD_KEY == 0) begin
                                c_q <= '0;
                                d_q <= '0;
                            end
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                            c_q   <= c_d;
                            d_q   <= d_d;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready    = (state_q == S_IDLE);
    assign sk_valid = (state_q == S_RUN);
    assign sk_round = mode_q ? (4'd15 - cnt_q) : cnt_q;
    assign done     = sk_valid && sk_ready && last_step;

    des_pc2 u_pc2 (
        .cd_i ({c_q, d_q}),
        .sk_o (sk_out)
    );

endmodule

// File: tb/tb_des_key_scheduler.sv
// -----------------------------------------------------------------------------
// tb_des_key_scheduler
// Two schedulers share one stimulus: u_dut_a with default parameters and
// u_dut_b built with DEC_EN=0, HOLD_KEY=0. Expected subkeys come from the
// published schedule for key 133457799BBCDFF1 and are queued when a start is
// driven; a negedge monitor compares each presented subkey against the queue
// head and pops on every transfer.
// -----------------------------------------------------------------------------
module tb_des_key_scheduler;

    typedef struct packed {
        logic [3:0]  round;
        logic [47:0] sk;
        logic        last;
    } exp_t;

    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
    localparam logic [47:0] KTAB [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic        sk_ready;
    logic [63:0] key_in;

    logic        ready_a, sk_valid_a, done_a;
    logic [47:0] sk_out_a;
    logic [3:0]  sk_round_a;
    logic        ready_b, sk_valid_b, done_b;
    logic [47:0] sk_out_b;
    logic [3:0]  sk_round_b;

    exp_t q_a [$];
    exp_t q_b [$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    des_key_scheduler u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_in   (key_in),
        .mode     (mode),
        .start    (start),
        .ready    (ready_a),
        .sk_out   (sk_out_a),
        .sk_round (sk_round_a),
        .sk_valid (sk_valid_a),
        .sk_ready (sk_ready),
        .done     (done_a)
    );

    des_key_scheduler #(.DEC_EN(0), .HOLD_KEY(0)) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_in   (key_in),
        .mode     (mode),
        .start    (start),
        .ready    (ready_b),
        .sk_out   (sk_out_b),
        .sk_round (sk_round_b),
        .sk_valid (sk_valid_b),
        .sk_ready (sk_ready),
        .done     (done_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    // Scoreboard monitor: peek while valid (covers hold under backpressure),
    // pop on transfer.
    always @(negedge clk) begin
        if (rst_n && sk_valid_a) begin
            check("a_pending", 64'(q_a.size() != 0), 64'd1);
            if (q_a.size() != 0) begin
                check("a_round",  64'(sk_round_a), 64'(q_a[0].round));
                check("a_subkey", 64'(sk_out_a),   64'(q_a[0].sk));
                check("a_done",   64'(done_a),     64'(sk_ready & q_a[0].last));
                if (sk_ready) void'(q_a.pop_front());
            end
        end
        if (rst_n && sk_valid_b) begin
            check("b_pending", 64'(q_b.size() != 0), 64'd1);
            if (q_b.size() != 0) begin
                check("b_round",  64'(sk_round_b), 64'(q_b[0].round));
                check("b_subkey", 64'(sk_out_b),   64'(q_b[0].sk));
                check("b_done",   64'(done_b),     64'(sk_ready & q_b[0].last));
                if (sk_ready) void'(q_b.pop_front());
            end
        end
    end

    task automatic push_sched(input logic m);
        for (int i = 0; i < 16; i++) begin
            exp_t e;
            e.round = m ? 4'(15 - i) : 4'(i);
            e.sk    = m ? KTAB[15 - i] : KTAB[i];
            e.last  = (i == 15);
            q_a.push_back(e);
            // DEC_EN=0 build always runs encrypt order.
            e.round = 4'(i);
            e.sk    = KTAB[i];
            q_b.push_back(e);
        end
    endtask

    // Entered and left at posedge+1 with both DUTs idle on entry.
    task automatic launch(input logic m);
        key_in = KEY;
        mode   = m;
        start  = 1'b1;
        push_sched(m);
        @(posedge clk); #1;
        start  = 1'b0;
        key_in = {$urandom, $urandom};
        mode   = ~m;
        @(negedge clk);
        check("lat1_a", 64'(sk_valid_a), 64'd1);
        check("lat1_b", 64'(sk_valid_b), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_q(input int n, input string tag);
        for (int c = 0; c < 100 && (q_a.size() > n || q_b.size() > n); c++) begin
            @(posedge clk); #1;
        end
        check(tag, 64'(q_a.size() + q_b.size()), 64'(2 * n));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready_a"}, 64'(ready_a),    64'd1);
        check({tag, "_valid_a"}, 64'(sk_valid_a), 64'd0);
        check({tag, "_done_a"},  64'(done_a),     64'd0);
        check({tag, "_sk_a"},    64'(sk_out_a),   64'd0);
        check({tag, "_round_a"}, 64'(sk_round_a), 64'd0);
        check({tag, "_ready_b"}, 64'(ready_b),    64'd1);
        check({tag, "_valid_b"}, 64'(sk_valid_b), 64'd0);
        check({tag, "_sk_b"},    64'(sk_out_b),   64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        mode     = 1'b0;
        sk_ready = 1'b1;
        key_in   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Encrypt order, full throughput.
        launch(1'b0);
        wait_q(0, "enc_drain");
        check("enc_hold_a",  64'(sk_out_a), 64'(KTAB[15]));
        check("enc_clear_b", 64'(sk_out_b), 64'd0);
        check("enc_ready_a", 64'(ready_a),  64'd1);

        // Decrypt order on A; B ignores mode.
        launch(1'b1);
        wait_q(0, "dec_drain");
        check("dec_hold_a",  64'(sk_out_a),   64'(KTAB[0]));
        check("dec_round_a", 64'(sk_round_a), 64'd0);

        // Backpressure at round 3.
        launch(1'b0);
        wait_q(14, "bp_reach");
        sk_ready = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("bp_round_a", 64'(sk_round_a), 64'd2);
        sk_ready = 1'b1;
        wait_q(0, "bp_drain");

        // start with a zero key mid-run is ignored.
        launch(1'b0);
        wait_q(10, "mid_reach");
        check("mid_ready_a", 64'(ready_a), 64'd0);
        key_in = '0;
        mode   = 1'b1;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        wait_q(0, "mid_drain");

        // start coinciding with the 16th transfer is ignored.
        launch(1'b0);
        wait_q(1, "last_reach");
        key_in = KEY;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        @(negedge clk);
        check("last_valid_a", 64'(sk_valid_a), 64'd0);
        check("last_ready_a", 64'(ready_a),    64'd1);
        check("last_valid_b", 64'(sk_valid_b), 64'd0);
        @(posedge clk); #1;

        // Reset mid-run, then a fresh schedule.
        launch(1'b0);
        wait_q(8, "rrun_reach");
        sk_ready = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        sk_ready = 1'b1;
        q_a.delete();
        q_b.delete();
        @(negedge clk);
        check_reset_state("midrst");
        @(posedge clk); #1;
        launch(1'b0);
        wait_q(0, "restart_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
